// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the MiniCPU control sequencer.
//   - opcode encodings (4-bit, taken from the top of the instruction word)
//   - ALU operation encodings
//   - sequencer state enumeration
package mc_ctrl_pkg;

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_LDA       = 4'h1;
    localparam logic [3:0] OP_LDB       = 4'h2;
    localparam logic [3:0] OP_ALU_FIRST = 4'h4;   // alu_op 000
    localparam logic [3:0] OP_ALU_LAST  = 4'hA;   // alu_op 110
    localparam logic [3:0] OP_BEQ       = 4'hB;
    localparam logic [3:0] OP_STORE     = 4'hC;
    localparam logic [3:0] OP_BNE       = 4'hD;
    localparam logic [3:0] OP_HALT      = 4'hF;

    localparam logic [2:0] ALU_NONE     = 3'b000;
    localparam logic [2:0] ALU_CMP      = 3'b111;  // compare used by branches

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_BRANCH,
        ST_HALTED
    } state_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational opcode decoder for the MiniCPU sequencer.
// Ports:
//   opcode   in  4  instruction opcode field
//   we_a     out 1  register A write
//   we_b     out 1  register B write
//   do_alu   out 1  ALU execute
//   alu_op   out 3  ALU operation (000 whenever do_alu is 0)
//   do_store out 1  store
//   is_beq   out 1  branch-if-zero instruction
//   is_bne   out 1  branch-if-not-zero instruction (only with the macro)
//   is_halt  out 1  HALT instruction
// Configuration: MINICPU_BRANCH_NE_EN enables opcode 1101 as BNE;
// otherwise it decodes as a NOP.
import mc_ctrl_pkg::*;

module mc_ctrl_decode (
    input  logic [3:0] opcode,
    output logic       we_a,
    output logic       we_b,
    output logic       do_alu,
    output logic [2:0] alu_op,
    output logic       do_store,
    output logic       is_beq,
    output logic       is_bne,
    output logic       is_halt
);

    always_comb begin
        we_a     = 1'b0;
        we_b     = 1'b0;
        do_alu   = 1'b0;
        alu_op   = ALU_NONE;
        do_store = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_halt  = 1'b0;
        if (opcode inside {[OP_ALU_FIRST:OP_ALU_LAST]}) begin
            do_alu = 1'b1;
            alu_op = 3'(opcode - OP_ALU_FIRST);
        end else begin
            case (opcode)
                OP_LDA:   we_a     = 1'b1;
                OP_LDB:   we_b     = 1'b1;
                OP_STORE: do_store = 1'b1;
                OP_HALT:  is_halt  = 1'b1;
                OP_BEQ: begin
                    is_beq = 1'b1;
                    do_alu = 1'b1;
                    alu_op = ALU_CMP;
                end
`ifdef MINICPU_BRANCH_NE_EN
                OP_BNE: begin
                    is_bne = 1'b1;
                    do_alu = 1'b1;
                    alu_op = ALU_CMP;
                end
`endif
                default: ;  // NOP and unassigned opcodes
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_seq.sv
// mc_ctrl_seq: multi-cycle MiniCPU control sequencer.
// Fetches over a req/ack handshake, decodes the 4-bit opcode and issues
// one-cycle control pulses in EXECUTE; branches resolve in BRANCH from zero.
// Parameters: IW instruction width (>=5), PCW program-counter width.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               leave IDLE/HALTED and fetch at pc
//   imem_req/imem_addr  fetch request and address (held until ack)
//   imem_ack/imem_rdata instruction return
//   zero                ALU zero flag, sampled in BRANCH
//   we_a, we_b, alu_op, do_alu, do_store   datapath control pulses
//   pc, busy, halted, instr_cnt            status
// Configuration: define MINICPU_BRANCH_NE_EN to decode opcode 1101 as BNE.
import mc_ctrl_pkg::*;

module mc_ctrl_seq #(
    parameter int unsigned IW  = 8,
    parameter int unsigned PCW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           imem_req,
    output logic [PCW-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [IW-1:0]  imem_rdata,
    input  logic           zero,
    output logic           we_a,
    output logic           we_b,
    output logic [2:0]     alu_op,
    output logic           do_alu,
    output logic           do_store,
    output logic [PCW-1:0] pc,
    output logic           busy,
    output logic           halted,
    output logic [15:0]    instr_cnt
);

    localparam int unsigned TW = IW - 4;  // branch target field width

    state_t         state, state_nx;
    logic [IW-1:0]  ir;
    logic [PCW-1:0] target;

    logic dec_we_a, dec_we_b, dec_do_alu, dec_do_store;
    logic dec_is_beq, dec_is_bne, dec_is_halt;
    logic [2:0] dec_alu_op;
    logic is_branch, taken;

    mc_ctrl_decode u_decode (
        .opcode   (ir[IW-1:IW-4]),
        .we_a     (dec_we_a),
        .we_b     (dec_we_b),
        .do_alu   (dec_do_alu),
        .alu_op   (dec_alu_op),
        .do_store (dec_do_store),
        .is_beq   (dec_is_beq),
        .is_bne   (dec_is_bne),
        .is_halt  (dec_is_halt)
    );

    // Target field resized to the pc width: truncated or zero-extended.
    generate
        if (TW >= PCW) begin : g_tgt_trunc
            assign target = ir[PCW-1:0];
        end else begin : g_tgt_zext
            assign target = {{(PCW - TW){1'b0}}, ir[TW-1:0]};
        end
    endgenerate

    assign is_branch = dec_is_beq | dec_is_bne;
    assign taken     = (dec_is_beq & zero) | (dec_is_bne & ~zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and outputs; controls depend on state and ir only.
    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        we_a      = 1'b0;
        we_b      = 1'b0;
        do_alu    = 1'b0;
        alu_op    = ALU_NONE;
        do_store  = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;
        imem_addr = pc;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ST_FETCH;
            end
            ST_HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (start) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                state_nx = dec_is_halt ? ST_HALTED : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                we_a     = dec_we_a;
                we_b     = dec_we_b;
                do_alu   = dec_do_alu;
                alu_op   = dec_alu_op;
                do_store = dec_do_store;
                state_nx = is_branch ? ST_BRANCH : ST_FETCH;
            end
            ST_BRANCH: begin
                state_nx = ST_FETCH;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir        <= '0;
            pc        <= '0;
            instr_cnt <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                        pc <= pc + PCW'(1);
                    end
                end
                ST_DECODE: begin
                    if (dec_is_halt) instr_cnt <= instr_cnt + 16'd1;
                end
                ST_EXECUTE: begin
                    if (!is_branch) instr_cnt <= instr_cnt + 16'd1;
                end
                ST_BRANCH: begin
                    instr_cnt <= instr_cnt + 16'd1;
                    // Overrides the increment applied during FETCH.
                    if (taken) pc <= target;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// tb_mc_ctrl_seq: self-checking bench for mc_ctrl_seq (IW=8, PCW=4).
// Expected control pulses are queued when an instruction is acknowledged and
// compared when the DUT raises any pulse; pc/latency/count are checked per
// instruction against a small bench-side model.
module tb_mc_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [7:0]  imem_rdata = '0;
    logic        zero = 1'b0;
    logic        we_a, we_b, do_alu, do_store;
    logic [2:0]  alu_op;
    logic [3:0]  pc;
    logic        busy, halted;
    logic [15:0] instr_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [6:0]  exp_q[$];
    logic [3:0]  pc_m = '0;
    logic [15:0] cnt_m = '0;
    logic [6:0]  mon_obs, mon_exp;

    mc_ctrl_seq #(.IW(8), .PCW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .zero       (zero),
        .we_a       (we_a),
        .we_b       (we_b),
        .alu_op     (alu_op),
        .do_alu     (do_alu),
        .do_store   (do_store),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {we_a, we_b, do_alu, alu_op, do_store} expected in EXECUTE.
    function automatic logic [6:0] exp_pulse(input logic [3:0] op, output bit has);
        logic [3:0] t;
        logic [6:0] r;
        t   = op - 4'd4;
        has = 1'b1;
        r   = '0;
        case (op)
            4'h1: r = 7'b1000000;
            4'h2: r = 7'b0100000;
            4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: r = {3'b001, t[2:0], 1'b0};
            4'hB: r = 7'b0011110;
            4'hC: r = 7'b0000001;
`ifdef MINICPU_BRANCH_NE_EN
            4'hD: r = 7'b0011110;
`endif
            default: has = 1'b0;
        endcase
        return r;
    endfunction

    function automatic bit is_br(input logic [3:0] op);
`ifdef MINICPU_BRANCH_NE_EN
        return (op == 4'hB) || (op == 4'hD);
`else
        return op == 4'hB;
`endif
    endfunction

    // Pulse monitor: any control pulse must match the head of the queue.
    always @(negedge clk) begin
        mon_obs = {we_a, we_b, do_alu, alu_op, do_store};
        if (mon_obs != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(mon_obs), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pulse", 32'(mon_obs), 32'(mon_exp));
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"},
              32'({imem_req, imem_addr, we_a, we_b, alu_op, do_alu, do_store, busy, halted}),
              32'd0);
        check({tag, "_pc_cnt"}, 32'({pc, instr_cnt}), 32'd0);
    endtask

    task automatic run_instr(input logic [7:0] instr, input int wait_cyc,
                             input logic zval, input logic hold_start);
        logic [3:0] op;
        logic [6:0] p;
        bit         has, br, taken;
        int         n;
        op   = instr[7:4];
        zero = zval;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        check("fetch_addr", 32'(imem_addr), 32'(pc_m));
        start = hold_start;
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clk);
            check("req_held", 32'({imem_req, imem_addr}), 32'({1'b1, pc_m}));
        end
        start      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = instr;
        p = exp_pulse(op, has);
        if (has) exp_q.push_back(p);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 8'($urandom);
        pc_m = pc_m + 4'd1;
        if (op == 4'hF) begin
            @(negedge clk);
            cnt_m = cnt_m + 16'd1;
            check("halt_flags", 32'({halted, busy, imem_req}), 32'b100);
            check("halt_pc", 32'(pc), 32'(pc_m));
            check("halt_cnt", 32'(instr_cnt), 32'(cnt_m));
            return;
        end
        br    = is_br(op);
        taken = br && ((op == 4'hB && zval) || (op == 4'hD && !zval));
        n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), br ? 32'd3 : 32'd2);
        if (taken) pc_m = instr[3:0];
        cnt_m = cnt_m + 16'd1;
        check("instr_cnt", 32'(instr_cnt), 32'(cnt_m));
        check("pulse_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("idle");

        do_start();
        run_instr(8'h13, 0, 1'b0, 1'b0);   // LDA @0
        run_instr(8'h40, 5, 1'b0, 1'b1);   // ADD @1, delayed ack, start held
        run_instr(8'hB9, 0, 1'b0, 1'b0);   // BEQ not taken @2 -> 3
        run_instr(8'h25, 1, 1'b0, 1'b0);   // LDB @3
        run_instr(8'hB2, 0, 1'b1, 1'b0);   // BEQ taken @4 -> 2
        run_instr(8'hB9, 0, 1'b1, 1'b0);   // BEQ taken @2 -> 9
        run_instr(8'hC0, 0, 1'b0, 1'b0);   // STORE @9
        run_instr(8'h2F, 2, 1'b0, 1'b0);   // LDB @10
        run_instr(8'hA0, 0, 1'b0, 1'b0);   // alu_op 110 @11
        run_instr(8'h30, 0, 1'b0, 1'b0);   // unassigned -> NOP @12
        run_instr(8'hE0, 0, 1'b0, 1'b0);   // unassigned -> NOP @13
        run_instr(8'h70, 0, 1'b0, 1'b0);   // alu_op 011 @14
        run_instr(8'h00, 0, 1'b0, 1'b0);   // NOP @15, pc wraps to 0
        run_instr(8'hD5, 0, 1'b0, 1'b0);   // BNE taken (macro) or NOP
        run_instr(8'hF0, 0, 1'b0, 1'b0);   // HALT
        repeat (2) @(negedge clk);
        check("halt_stays", 32'({halted, busy, imem_req}), 32'b100);
        do_start();
        run_instr(8'h13, 0, 1'b0, 1'b0);   // resume at pc

        // Reset during a pending fetch, then a stray ack while IDLE.
        check("pending_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("mid_fetch_reset");
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 8'h13;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("stray_ack");
        pc_m  = '0;
        cnt_m = '0;
        do_start();
        run_instr(8'h21, 0, 1'b0, 1'b0);   // LDB @0 after reset
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_seq.md
# mc_ctrl_seq

Parametrised multi-cycle sequencer for the MiniCPU datapath. It fetches instructions over a req/ack handshake with instruction memory, decodes the 4-bit opcode, and issues one-cycle control pulses to the register file, ALU and store path. It resolves branches from the ALU zero flag one cycle after the compare and supports a HALT instruction with restart. It sits between instruction memory and the datapath, replacing the fixed 8-bit/4-bit-PC controller.

## Interface
- IW, 8: instruction width; opcode is ir[IW-1:IW-4]; branch target field is ir[IW-5:0]. IW ≥ 5.
- PCW, 4: program counter / instruction address width.
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  leave IDLE/HALTED and begin fetching at current pc.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  PCW  fetch address, equal to pc while imem_req=1.
- imem_ack  in  1  instruction returned on imem_rdata this cycle.
- imem_rdata  in  IW  instruction word.
- zero  in  1  ALU zero flag, valid the cycle after the do_alu pulse.
- we_a, we_b  out  1  register A/B write pulse.
- alu_op  out  3  ALU operation.
- do_alu  out  1  ALU execute pulse.
- do_store  out  1  store pulse.
- pc  out  PCW  program counter.
- busy  out  1  high in every state except IDLE and HALTED.
- halted  out  1  high in HALTED.
- instr_cnt  out  16  number of completed instructions, wraps at 2^16.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, BRANCH, HALTED.
- IDLE/HALTED → FETCH on start=1. start is ignored in all other states.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: ir ← imem_rdata; pc ← pc+1 mod 2^PCW; → DECODE. Without ack, remain in FETCH indefinitely. imem_ack outside FETCH is ignored.
- DECODE: one cycle → EXECUTE. HALT instead goes → HALTED and counts as completed.
- Opcodes:
  - 0000 NOP
  - 0001 LDA (we_a)
  - 0010 LDB (we_b)
  - 0100–1010 ALU ops with alu_op 000–110 and do_alu
  - 1011 BEQ
  - 1100 STORE (do_store)
  - 1101 BNE (see Configuration)
  - 1111 HALT
  - Any other opcode is a NOP.
- EXECUTE: the decoded pulse is high for exactly this cycle. BEQ/BNE drive alu_op=111 and do_alu=1, then → BRANCH. All other opcodes → FETCH.
- BRANCH: sample zero. Taken when BEQ and zero=1, or BNE and zero=0. If taken, pc ← zero-extended or truncated ir[IW-5:0] to PCW bits. → FETCH.
- Control outputs derive only from state and ir. There is no combinational path from any input to we_a, we_b, alu_op, do_alu or do_store.
- alu_op=000 whenever do_alu=0.
- instr_cnt increments on the last cycle of every instruction (EXECUTE for non-branch, BRANCH, or DECODE for HALT).

## Timing
- Reset values: state=IDLE, pc=0, ir=0, instr_cnt=0, and every output 0 except imem_addr=0.
- Non-branch instruction latency: FETCH (1+wait) + DECODE + EXECUTE = 3 cycles at zero wait.
- Branch instruction latency: 4 cycles.
- HALT latency: FETCH + DECODE = 2 cycles.
- pc wrap: fetching at 2^PCW−1 sets pc=0.
- A taken branch overrides the increment already applied in FETCH.
- Reset mid-fetch or mid-execute: immediate return to reset values. A pending request is dropped, and any ack after reset is ignored.

## Configuration
- MINICPU_BRANCH_NE_EN defined: opcode 1101 is BNE.
- MINICPU_BRANCH_NE_EN undefined: opcode 1101 decodes as NOP with 3-cycle latency and no do_alu pulse.

## Structure
- Package mc_ctrl_pkg: opcode localparams, alu_op localparams, state enum.
- Sub-module mc_ctrl_decode: combinational opcode → {we_a, we_b, do_alu, alu_op, do_store, is_beq, is_bne, is_halt}. The sequencer registers ir and gates these signals with EXECUTE.

## Test plan
- Reset, start, program at 0: 0x1_3 (LDA), zero-wait ack → we_a high in cycle 3 only; pc=1; instr_cnt=1.
- ADD with ack delayed 5 cycles → imem_req held with imem_addr stable; do_alu=1 and alu_op=000 one cycle; no other pulses.
- BEQ target 9 at pc=2 with zero=1 → pc=9 after BRANCH. Same with zero=0 → pc=3. With PCW=4, IW=8.
- pc=15 executing NOP → next fetch address 0.
- HALT → halted=1, busy=0, pc unchanged. start → resumes fetch at pc. start during FETCH has no effect.
- 0xD5 with the macro on and zero=0 → branch to 5. With the macro off → NOP, pc+1. rst_n pulsed during a pending fetch → all outputs 0 next cycle.
